// File: rtl/snake_game_ctrl.sv
// snake_game_ctrl: button conditioning, IDLE/PLAY/PAUSE/OVER game FSM,
// movement tick scheduling with reversal-protected direction, length/score.
module snake_game_ctrl #(
    parameter int unsigned TICK_CYCLES = 10000000,
    parameter int unsigned DEB_CYCLES  = 1000000,
    parameter int unsigned MAX_LEN     = 30,
    parameter int unsigned INIT_LEN    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              left,
    input  logic              right,
    input  logic              up,
    input  logic              down,
    input  logic              food_eaten,
    input  logic              self_hit,
    output logic              move_tick,
    output logic              clear,
    output logic signed [1:0] dir_x,
    output logic signed [1:0] dir_y,
    output logic [7:0]        snake_len,
    output logic [15:0]       score,
    output logic [1:0]        state
);

    localparam int unsigned NBTN    = 5;
    localparam int unsigned TW      = $clog2(TICK_CYCLES);
    localparam int unsigned DW      = $clog2(DEB_CYCLES);
    localparam int unsigned B_START = 0;
    localparam int unsigned B_LEFT  = 1;
    localparam int unsigned B_RIGHT = 2;
    localparam int unsigned B_UP    = 3;
    localparam int unsigned B_DOWN  = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PLAY  = 2'b01,
        S_PAUSE = 2'b10,
        S_OVER  = 2'b11
    } state_t;

    logic [NBTN-1:0]         btn_raw;
    logic [NBTN-1:0]         sync1;
    logic [NBTN-1:0]         sync2;
    logic [NBTN-1:0]         deb;
    logic [NBTN-1:0]         deb_d;
    logic [NBTN-1:0]         press;
    logic [NBTN-1:0][DW-1:0] deb_cnt;

    state_t                  state_q;
    state_t                  state_n;
    logic [TW-1:0]           cnt_q;
    logic [TW-1:0]           cnt_n;
    logic signed [1:0]       pend_x;
    logic signed [1:0]       pend_y;
    logic signed [1:0]       pend_x_n;
    logic signed [1:0]       pend_y_n;
    logic signed [1:0]       dir_x_n;
    logic signed [1:0]       dir_y_n;
    logic [7:0]              len_n;
    logic [15:0]             score_n;
    logic                    tick_n;
    logic                    clear_n;

    logic                    cand_vld;
    logic signed [1:0]       cand_x;
    logic signed [1:0]       cand_y;
    logic signed [1:0]       neg_x;
    logic signed [1:0]       neg_y;
    logic                    leaving;

    assign btn_raw = {down, up, right, left, start};
    assign state   = state_q;

    // Synchronize, debounce with a stability counter, and pulse on debounced rise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= '0;
            sync2   <= '0;
            deb     <= '0;
            deb_d   <= '0;
            press   <= '0;
            deb_cnt <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            for (int i = 0; i < int'(NBTN); i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
            deb_d <= deb;
            press <= deb & ~deb_d;
        end
    end

    // Direction candidate by press priority left > right > up > down
    always_comb begin
        cand_vld = 1'b1;
        cand_x   = 2'sb00;
        cand_y   = 2'sb00;
        if (press[B_LEFT]) begin
            cand_x = 2'sb11;
        end else if (press[B_RIGHT]) begin
            cand_x = 2'sb01;
        end else if (press[B_UP]) begin
            cand_y = 2'sb11;
        end else if (press[B_DOWN]) begin
            cand_y = 2'sb01;
        end else begin
            cand_vld = 1'b0;
        end
        neg_x = -dir_x;
        neg_y = -dir_y;
    end

    // Game state register and datapath-facing outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_x    <= 2'sb00;
            pend_y    <= 2'sb01;
            dir_x     <= 2'sb00;
            dir_y     <= 2'sb01;
            snake_len <= 8'(INIT_LEN);
            score     <= '0;
            move_tick <= 1'b0;
            clear     <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            pend_x    <= pend_x_n;
            pend_y    <= pend_y_n;
            dir_x     <= dir_x_n;
            dir_y     <= dir_y_n;
            snake_len <= len_n;
            score     <= score_n;
            move_tick <= tick_n;
            clear     <= clear_n;
        end
    end

    // Next-state: game transitions, eat accounting, pending/committed direction, tick
    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        pend_x_n = pend_x;
        pend_y_n = pend_y;
        dir_x_n  = dir_x;
        dir_y_n  = dir_y;
        len_n    = snake_len;
        score_n  = score;
        tick_n   = 1'b0;
        clear_n  = 1'b0;
        leaving  = self_hit | press[B_START];

        case (state_q)
            S_IDLE: begin
                if (press[B_START]) begin
                    state_n  = S_PLAY;
                    score_n  = '0;
                    len_n    = 8'(INIT_LEN);
                    dir_x_n  = 2'sb00;
                    dir_y_n  = 2'sb01;
                    pend_x_n = 2'sb00;
                    pend_y_n = 2'sb01;
                    cnt_n    = '0;
                    clear_n  = 1'b1;
                end
            end
            S_PLAY: begin
                if (food_eaten) begin
                    if (score != 16'hFFFF) score_n = score + 16'd1;
                    if (snake_len < 8'(MAX_LEN)) len_n = snake_len + 8'd1;
                end
                if (cand_vld && !((cand_x == neg_x) && (cand_y == neg_y))) begin
                    pend_x_n = cand_x;
                    pend_y_n = cand_y;
                end
                // The clear cycle does not advance the phase; leaving PLAY freezes it
                if (!leaving && !clear) begin
                    if (cnt_q == TW'(TICK_CYCLES - 1)) begin
                        cnt_n   = '0;
                        dir_x_n = pend_x;
                        dir_y_n = pend_y;
                        tick_n  = 1'b1;
                    end else begin
                        cnt_n = cnt_q + TW'(1);
                    end
                end
                if (self_hit) begin
                    state_n = S_OVER;
                end else if (press[B_START]) begin
                    state_n = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (press[B_START]) state_n = S_PLAY;
            end
            S_OVER: begin
                if (press[B_START]) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: doc/snake_game_ctrl.md
# snake_game_ctrl

Game-level controller for the snake datapath. It debounces the raw push-buttons and runs the IDLE/PLAY/PAUSE/OVER state machine. It schedules the movement tick and commits direction changes only on tick boundaries, with reversal protection. It also tracks snake length and score from the datapath's eat and collision flags, and drives the datapath's step enable, direction, length and clear inputs.

## Interface
- TICK_CYCLES, 10000000, clk cycles per movement step (≥4)
- DEB_CYCLES, 1000000, cycles a synchronized button must stay high to count as pressed (≥2)
- MAX_LEN, 30, length saturation limit
- INIT_LEN, 5, length loaded at game start (≤MAX_LEN)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  raw start/pause button, asynchronous
- left, right, up, down  in  1 each  raw direction buttons, asynchronous
- food_eaten  in  1  one-cycle pulse from datapath: head overlapped food
- self_hit  in  1  level from datapath: head overlapped body
- move_tick  out  1  one-cycle step enable to datapath
- clear  out  1  one-cycle pulse: datapath reinitializes body positions
- dir_x, dir_y  out  2 each, signed  committed direction, each in {-1,0,+1}
- snake_len  out  8  current length
- score  out  16  food count
- state  out  2  00 IDLE, 01 PLAY, 10 PAUSE, 11 OVER

## Operation
- Button conditioning (each of 5 buttons):
  - 2-flop synchronizer, then a stability counter.
  - Debounced level rises after the synchronized level has been 1 for DEB_CYCLES consecutive cycles. It falls after 0 for DEB_CYCLES.
  - Registered press pulse on each debounced rising edge. Holding a button gives exactly one pulse.
- FSM, driven by the start press pulse:
  - IDLE→PLAY: score←0, snake_len←INIT_LEN, dir←(0,+1), pending dir←(0,+1), tick counter←0, clear=1 for that cycle.
  - PLAY→PAUSE and PAUSE→PLAY on start press. Tick counter holds in PAUSE, so the phase is preserved.
  - PLAY→OVER when self_hit=1 in any PLAY cycle. Takes priority over a simultaneous start press.
  - OVER→IDLE on start press.
  - self_hit and food_eaten are ignored outside PLAY.
- Direction:
  - Pending register updated by direction presses in PLAY only.
  - Simultaneous presses: priority left > right > up > down.
  - A candidate equal to the negation of the committed direction is discarded (left rejected while dir=(+1,0), etc.). Reversal is checked against committed, not pending, so two presses within one tick cannot reverse.
  - Mapping: left (-1,0), right (+1,0), up (0,-1), down (0,+1).
- Tick:
  - Counter runs 0..TICK_CYCLES-1 in PLAY only.
  - At count TICK_CYCLES-1: committed dir←pending, counter wraps to 0.
  - move_tick is a registered pulse in the following cycle, so dir is stable while move_tick=1.
- Eat (food_eaten=1 in PLAY):
  - score+1, saturating at 16'hFFFF.
  - snake_len+1, saturating at MAX_LEN.
  - Same-cycle food_eaten and self_hit: increment applies and state goes OVER.
- In OVER: move_tick never asserted; score, snake_len and dir hold until the next IDLE→PLAY.

## Timing
- Reset values: state=IDLE, move_tick=0, clear=0, dir=(0,+1), snake_len=INIT_LEN, score=0, all debouncers and counters 0.
- Raw button rise to press pulse high: DEB_CYCLES+3 clock edges (sync 2, debounce DEB_CYCLES, pulse register 1).
- State, score and snake_len update on the edge after the causing press or flag is sampled.
- clear is high in the same cycle state first reads PLAY from IDLE.
- First move_tick after IDLE→PLAY: TICK_CYCLES+1 cycles after clear. Thereafter one every TICK_CYCLES cycles while in PLAY.
- A tick pending when PAUSE is entered is not lost: it fires after resume, once the remaining count elapses.
- Leaving PLAY in the same cycle the counter hits TICK_CYCLES-1: no move_tick is issued.
- Reset asserted mid-game: all outputs return to reset values immediately (asynchronous). No clear pulse is generated.

## Test plan
Benches use TICK_CYCLES=8, DEB_CYCLES=4, MAX_LEN=7, INIT_LEN=5.

1. Reset, then start held 20 cycles → single press. state=01, clear=1 for one cycle, score=0, len=5; move_tick every 8 cycles.
2. In PLAY with dir=(0,+1), press left then up within one tick period → dir becomes (-1,0) at the next tick (up was stored last but (0,-1) is rejected as a reversal of the committed (0,+1)). A raw 3-cycle glitch on right produces no press.
3. Eight food_eaten pulses → score=8 and len saturates at 7. food_eaten in PAUSE leaves both unchanged.
4. Start press in PLAY → PAUSE with no move_tick for 50 cycles. Resume → first tick arrives after the remaining count, not a full period.
5. self_hit and food_eaten in the same PLAY cycle → state=11, score+1. Later start press → IDLE; another → PLAY with score=0, len=5.
6. Reset pulsed low for 1 cycle while in PLAY mid-tick → all outputs at reset values on the next sample, state=00.
